// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serialiser.
// Line output is registered and follows the FSM's next state.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int FIFO_AW      = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               UART_tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   state_e             state_q, state_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               tx_q, tx_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic [7:0]         mem [FIFO_DEPTH];

   logic full, empty, push, pop, bit_done;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign push     = tx_valid && !full;
   assign bit_done = (timer_q == TMAX);

   assign tx_ready   = !full;
   assign UART_tx    = tx_q;
   assign busy       = (state_q != IDLE) || !empty;
   assign fifo_count = count_q;

   // FSM state, bit timer, shifter and FIFO bookkeeping registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage; contents are abandoned on reset via the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= tx_data;
      end
   end

   // Next state and pop decision
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done && (idx_q == 3'd7)) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bit timer, bit index and shift register update
   always_comb begin
      timer_d = bit_done ? '0 : timer_q + 1'b1;
      if ((state_d != state_q) || (state_q == IDLE)) begin
         timer_d = '0;
      end
      idx_d   = idx_q;
      shift_d = shift_q;
      if (pop) begin
         shift_d = mem[rd_ptr_q];
      end else if ((state_q == DATA) && bit_done) begin
         shift_d = shift_q >> 1;
         idx_d   = idx_q + 3'd1;
      end
      if ((state_d == DATA) && (state_q != DATA)) begin
         idx_d = '0;
      end
   end

   // FIFO pointers and occupancy count
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Line level for the upcoming cycle, taken from the next state
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the full CPU design; the counterpart to the existing `UART_rx` input. It takes bytes from the core over a valid/ready handshake and buffers them in an internal FIFO. Each byte is serialised as a standard 8N1 frame on `UART_tx`, so the host PC's serial terminal can receive CPU output and loader echoes. The block sits between the CPU's I/O write port and the board's TX pin.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: byte FIFO depth. Must be a power of two.
- `FIFO_AW`, default 4: log2(`FIFO_DEPTH`).

Ports:
- `clk`  input  1: system clock, 100 MHz.
- `rst`  input  1: asynchronous, active-high reset.
- `tx_data`  input  8: byte to send. Sampled only on handshake.
- `tx_valid`  input  1: producer has a byte.
- `tx_ready`  output  1: FIFO can accept a byte; equals `!full`.
- `UART_tx`  output  1: serial line, idle high. Registered.
- `busy`  output  1: high when a frame is in flight or the FIFO is non-empty.
- `fifo_count`  output  `FIFO_AW+1`: number of bytes currently buffered.

## Operation
- Reset values: `UART_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0. FSM resets to IDLE; FIFO pointers are zeroed.
- Push: a byte is written on any rising edge where `tx_valid && tx_ready`.
- `tx_ready` is derived from the registered count only. There is no bypass: a pop in the same cycle does not free a slot for a push while full.
- Frame format: start bit (0), then `tx_data[0]` through `tx_data[7]` (LSB first), then one stop bit (1). No parity. Each bit is held for exactly `CLKS_PER_BIT` cycles.
- FSM states:
  - IDLE: `UART_tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `UART_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: drive `shift[0]`. On bit-timer expiry, shift right and increment the index. After index 7 expires, go to STOP.
  - STOP: `UART_tx`=1 for `CLKS_PER_BIT` cycles. On expiry, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Bit timer: counts 0 to `CLKS_PER_BIT-1`, wraps to 0 on each bit boundary, and is cleared on every state entry.
- FIFO pointers: `FIFO_AW` bits wide and wrap modulo `FIFO_DEPTH`. Count is maintained separately:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Empty and push in the same cycle: the push lands and the pop occurs on the next cycle.
- `busy` = (state != IDLE) || (`fifo_count` != 0). Combinational from registers.
- Reset mid-frame:
  - `UART_tx` returns high immediately (asynchronous).
  - The frame is truncated and the FIFO contents are discarded.
  - No partial byte is retransmitted after reset is released.

## Timing
- Acceptance at edge N → `fifo_count`=1 after N. IDLE pops at edge N+1 → `UART_tx` falls after edge N+1, i.e. one cycle of latency.
- Single frame: 10×`CLKS_PER_BIT` cycles from start-bit fall to the end of the stop bit. `busy` falls on the same edge that returns the FSM to IDLE.
- Back-to-back frames are contiguous: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `tx_data` and `tx_valid` may change freely when `tx_ready` is low. Nothing is latched without a handshake.

## Test plan
Directed tests use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16.

1. Reset, then idle for 50 cycles → `UART_tx`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0 throughout.
2. One push of 0x55 → `UART_tx` falls one cycle after acceptance. The line then carries:
   - 0 for 4 cycles (start),
   - bits 1,0,1,0,1,0,1,0 for 4 cycles each,
   - 1 for 4 cycles (stop).
   
   `busy` deasserts exactly 40 cycles after the fall.
3. Push 0xA5 then 0x3C on consecutive cycles → 80 contiguous line cycles. Decoded bytes are 0xA5 then 0x3C, with no high gap between the first stop bit and the second start bit.
4. Hold `tx_valid` high with incrementing data starting at 0x00 → exactly 17 bytes are accepted before `tx_ready` first falls (one popped immediately), with `fifo_count`=16 at that point. All 17 bytes are later decoded in order, 0x00 through 0x10.
5. Assert `rst` during the DATA state of a 0xFF frame with 3 bytes queued → `UART_tx`=1 within the same cycle and `fifo_count`=0. After release, the line stays high and no residual frames are sent.
6. Toggle `tx_data` while `tx_valid`=0, and push attempts while full → no extra bytes appear on the line and `fifo_count` never exceeds 16.
